// File: rtl/ripple_count_monitor.sv
// -----------------------------------------------------------------------------
// ripple_count_monitor
//
// Purpose:
//    Consumes the raw output of a ripple counter. Because ripple outputs
//    settle bit by bit, the raw count is first filtered: a value is accepted
//    only after it has been sampled unchanged on STABLE_CYCLES+2 consecutive
//    edges. Each accepted change is classified as a wrap (max -> 0), a skip
//    (anything other than +1) or a threshold hit (arrival at THRESH). The
//    resulting event is offered through a single-entry valid/ready register.
//    A running modulo count of wraps is also kept.
//
// Ports:
//    clk           in   system clock, rising edge
//    rst           in   synchronous active-high reset (priority over clr)
//    cnt_in        in   raw ripple counter value
//    clr           in   synchronous clear of wrap count, overflow, event reg
//                       and stable_valid (filter state and cnt_stable kept)
//    cnt_stable    out  last accepted count
//    stable_valid  out  a value has been accepted since reset/clr
//    upd_pulse     out  one-cycle pulse on each accept
//    wrap_count    out  number of wrap events, modulo 2^WRAP_WIDTH
//    evt_valid     out  event register occupied
//    evt_ready     in   consumer takes the event
//    evt_code      out  01 wrap, 10 skip, 11 threshold, 00 idle
//    evt_value     out  cnt_stable value that produced the event
//    evt_overflow  out  sticky: an event was dropped
// -----------------------------------------------------------------------------
module ripple_count_monitor #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 2,
   parameter int THRESH        = 10,
   parameter int WRAP_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      cnt_in,
   input  logic                  clr,
   output logic [WIDTH-1:0]      cnt_stable,
   output logic                  stable_valid,
   output logic                  upd_pulse,
   output logic [WRAP_WIDTH-1:0] wrap_count,
   output logic                  evt_valid,
   input  logic                  evt_ready,
   output logic [1:0]            evt_code,
   output logic [WIDTH-1:0]      evt_value,
   output logic                  evt_overflow
);

   localparam int               SC_W     = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STABLE_CYCLES);
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] THR_VAL  = WIDTH'(THRESH);

   localparam logic [1:0] EVT_NONE   = 2'b00;
   localparam logic [1:0] EVT_WRAP   = 2'b01;
   localparam logic [1:0] EVT_SKIP   = 2'b10;
   localparam logic [1:0] EVT_THRESH = 2'b11;

   // filter state
   logic [WIDTH-1:0]      s_q, s_d;
   logic [SC_W-1:0]       sc_q, sc_d;
   // published value
   logic [WIDTH-1:0]      cnt_stable_q, cnt_stable_d;
   logic                  stable_valid_q, stable_valid_d;
   logic                  upd_pulse_q, upd_pulse_d;
   // statistics and event register
   logic [WRAP_WIDTH-1:0] wrap_count_q, wrap_count_d;
   logic                  evt_valid_q, evt_valid_d;
   logic [1:0]            evt_code_q, evt_code_d;
   logic [WIDTH-1:0]      evt_value_q, evt_value_d;
   logic                  evt_overflow_q, evt_overflow_d;

   // combinational helpers
   logic                  match_s;
   logic                  accept_s;
   logic [1:0]            new_code_s;
   logic                  pop_s;

   // Filter, accept decision, classification and next-state for all registers.
   always_comb begin
      s_d            = cnt_in;
      sc_d           = sc_q;
      cnt_stable_d   = cnt_stable_q;
      stable_valid_d = stable_valid_q;
      upd_pulse_d    = 1'b0;
      wrap_count_d   = wrap_count_q;
      evt_valid_d    = evt_valid_q;
      evt_code_d     = evt_code_q;
      evt_value_d    = evt_value_q;
      evt_overflow_d = evt_overflow_q;
      new_code_s     = EVT_NONE;

      match_s = (cnt_in == s_q);

      // saturating run counter; any difference restarts it
      if (!match_s) begin
         sc_d = {SC_W{1'b0}};
      end else if (sc_q == SC_MAX) begin
         sc_d = sc_q;
      end else begin
         sc_d = sc_q + SC_W'(1);
      end

      // the "!stable_valid" term lets a value equal to cnt_stable be
      // re-accepted (silently) after a clr
      accept_s = match_s && (sc_q == SC_MAX) &&
                 ((s_q != cnt_stable_q) || !stable_valid_q);

      // only a change relative to an already-valid value is classified
      if (accept_s && stable_valid_q) begin
         if ((cnt_stable_q == CNT_MAX) && (s_q == CNT_ZERO)) begin
            new_code_s = EVT_WRAP;
         end else if (s_q != (cnt_stable_q + WIDTH'(1))) begin
            new_code_s = EVT_SKIP;
         end else if (s_q == THR_VAL) begin
            new_code_s = EVT_THRESH;
         end else begin
            new_code_s = EVT_NONE;
         end
      end else begin
         new_code_s = EVT_NONE;
      end

      pop_s = evt_valid_q && evt_ready;

      if (clr) begin
         // clr suppresses any accept/event on this edge
         stable_valid_d = 1'b0;
         wrap_count_d   = {WRAP_WIDTH{1'b0}};
         evt_valid_d    = 1'b0;
         evt_code_d     = EVT_NONE;
         evt_value_d    = CNT_ZERO;
         evt_overflow_d = 1'b0;
      end else begin
         if (accept_s) begin
            cnt_stable_d   = s_q;
            stable_valid_d = 1'b1;
            upd_pulse_d    = 1'b1;
         end else begin
            cnt_stable_d   = cnt_stable_q;
         end

         // wraps are counted even when the event itself is dropped
         if (new_code_s == EVT_WRAP) begin
            wrap_count_d = wrap_count_q + WRAP_WIDTH'(1);
         end else begin
            wrap_count_d = wrap_count_q;
         end

         if (new_code_s != EVT_NONE) begin
            if (!evt_valid_q || pop_s) begin
               evt_valid_d = 1'b1;
               evt_code_d  = new_code_s;
               evt_value_d = s_q;
            end else begin
               // held event stays; the newcomer is lost
               evt_overflow_d = 1'b1;
            end
         end else if (pop_s) begin
            evt_valid_d = 1'b0;
            evt_code_d  = EVT_NONE;
            evt_value_d = CNT_ZERO;
         end else begin
            evt_valid_d = evt_valid_q;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q            <= CNT_ZERO;
         sc_q           <= {SC_W{1'b0}};
         cnt_stable_q   <= CNT_ZERO;
         stable_valid_q <= 1'b0;
         upd_pulse_q    <= 1'b0;
         wrap_count_q   <= {WRAP_WIDTH{1'b0}};
         evt_valid_q    <= 1'b0;
         evt_code_q     <= EVT_NONE;
         evt_value_q    <= CNT_ZERO;
         evt_overflow_q <= 1'b0;
      end else begin
         s_q            <= s_d;
         sc_q           <= sc_d;
         cnt_stable_q   <= cnt_stable_d;
         stable_valid_q <= stable_valid_d;
         upd_pulse_q    <= upd_pulse_d;
         wrap_count_q   <= wrap_count_d;
         evt_valid_q    <= evt_valid_d;
         evt_code_q     <= evt_code_d;
         evt_value_q    <= evt_value_d;
         evt_overflow_q <= evt_overflow_d;
      end
   end

   assign cnt_stable   = cnt_stable_q;
   assign stable_valid = stable_valid_q;
   assign upd_pulse    = upd_pulse_q;
   assign wrap_count   = wrap_count_q;
   assign evt_valid    = evt_valid_q;
   assign evt_code     = evt_code_q;
   assign evt_value    = evt_value_q;
   assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_ripple_count_monitor
//
// Self-checking bench for ripple_count_monitor. A reference model tracks the
// raw count as "value + how many consecutive edges it has been seen" and
// applies the accept/classify/event rules with plain integer arithmetic.
// Directed scenarios come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_ripple_count_monitor;

   localparam int W   = 4;
   localparam int SC  = 2;
   localparam int TH  = 10;
   localparam int WW  = 8;
   localparam int MODV = 1 << W;
   localparam int MODW = 1 << WW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  cnt_in = '0;
   logic          clr = 1'b0;
   logic [W-1:0]  cnt_stable;
   logic          stable_valid;
   logic          upd_pulse;
   logic [WW-1:0] wrap_count;
   logic          evt_valid;
   logic          evt_ready = 1'b0;
   logic [1:0]    evt_code;
   logic [W-1:0]  evt_value;
   logic          evt_overflow;

   ripple_count_monitor #(
      .WIDTH(W), .STABLE_CYCLES(SC), .THRESH(TH), .WRAP_WIDTH(WW)
   ) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
      .cnt_stable(cnt_stable), .stable_valid(stable_valid),
      .upd_pulse(upd_pulse), .wrap_count(wrap_count),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_code(evt_code), .evt_value(evt_value),
      .evt_overflow(evt_overflow)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_prev, m_run;
   int m_cs, m_sv, m_upd, m_wc, m_ev, m_ec, m_evv, m_ovf;

   // observation counters for directed scenarios
   int n_upd, n_evt_cycles;
   int ev_code_q[$];
   int ev_val_q[$];

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int run_after(input int cin);
      return (cin == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
   endfunction

   function automatic bit would_accept(input int cin);
      return (run_after(cin) >= SC + 2) && ((cin != m_cs) || (m_sv == 0));
   endfunction

   task automatic model_reset();
      m_prev = 0; m_run = 1;
      m_cs = 0; m_sv = 0; m_upd = 0; m_wc = 0;
      m_ev = 0; m_ec = 0; m_evv = 0; m_ovf = 0;
   endtask

   task automatic model_edge(input int cin, input bit c, input bit rdy, input bit r);
      int code;
      bit acc;
      if (r) begin
         model_reset();
         return;
      end
      acc = would_accept(cin);
      if (c) begin
         m_sv = 0; m_upd = 0; m_wc = 0;
         m_ev = 0; m_ec = 0; m_evv = 0; m_ovf = 0;
      end else begin
         code = 0;
         if (acc && m_sv == 1) begin
            if (m_cs == MODV - 1 && cin == 0) code = 1;
            else if (cin != (m_cs + 1) % MODV) code = 2;
            else if (cin == TH) code = 3;
         end
         m_upd = acc ? 1 : 0;
         if (acc) begin
            m_cs = cin;
            m_sv = 1;
         end
         if (code == 1) m_wc = (m_wc + 1) % MODW;
         if (code != 0) begin
            if (m_ev == 0 || rdy) begin
               m_ev = 1; m_ec = code; m_evv = cin;
            end else begin
               m_ovf = 1;
            end
         end else if (m_ev == 1 && rdy) begin
            m_ev = 0; m_ec = 0; m_evv = 0;
         end
      end
      m_run  = run_after(cin);
      m_prev = cin;
   endtask

   task automatic step(input int cin, input bit c, input bit rdy, input bit r);
      @(negedge clk);
      cnt_in    = cin[W-1:0];
      clr       = c;
      evt_ready = rdy;
      rst       = r;
      @(posedge clk);
      model_edge(cin, c, rdy, r);
      #1;
      check_eq("cnt_stable",   int'(cnt_stable),   m_cs);
      check_eq("stable_valid", int'(stable_valid), m_sv);
      check_eq("upd_pulse",    int'(upd_pulse),    m_upd);
      check_eq("wrap_count",   int'(wrap_count),   m_wc);
      check_eq("evt_valid",    int'(evt_valid),    m_ev);
      check_eq("evt_code",     int'(evt_code),     m_ec);
      check_eq("evt_value",    int'(evt_value),    m_evv);
      check_eq("evt_overflow", int'(evt_overflow), m_ovf);
      if (upd_pulse) n_upd++;
      if (evt_valid) begin
         n_evt_cycles++;
         ev_code_q.push_back(int'(evt_code));
         ev_val_q.push_back(int'(evt_value));
      end
   endtask

   task automatic hold(input int cin, input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(cin, 1'b0, rdy, 1'b0);
   endtask

   task automatic clear_obs();
      n_upd = 0; n_evt_cycles = 0;
      ev_code_q.delete();
      ev_val_q.delete();
   endtask

   initial begin
      model_reset();
      clear_obs();

      // --- reset, then 0 held
      step(0, 1'b0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b0, 1'b1);
      check_eq("rst_cnt_stable", int'(cnt_stable), 0);
      check_eq("rst_stable_valid", int'(stable_valid), 0);
      check_eq("rst_evt_valid", int'(evt_valid), 0);
      clear_obs();
      hold(0, 4, 1'b0);
      check_eq("t1_stable_valid", int'(stable_valid), 1);
      check_eq("t1_cnt_stable", int'(cnt_stable), 0);
      check_eq("t1_upd_count", n_upd, 1);
      check_eq("t1_evt_cycles", n_evt_cycles, 0);

      // --- full count sweep 1..15 then 0
      clear_obs();
      for (int v = 1; v <= MODV; v++) hold(v % MODV, 6, 1'b1);
      check_eq("t2_upd_count", n_upd, 16);
      check_eq("t2_evt_count", n_evt_cycles, 2);
      if (n_evt_cycles == 2) begin
         check_eq("t2_ev0_code", ev_code_q[0], 3);
         check_eq("t2_ev0_val",  ev_val_q[0], 10);
         check_eq("t2_ev1_code", ev_code_q[1], 1);
         check_eq("t2_ev1_val",  ev_val_q[1], 0);
      end
      check_eq("t2_wrap_count", int'(wrap_count), 1);

      // --- glitch rejection around 5
      hold(5, 6, 1'b1);
      hold(5, 2, 1'b1);
      clear_obs();
      step(7, 1'b0, 1'b1, 1'b0);
      hold(5, 6, 1'b1);
      check_eq("t3_cnt_stable", int'(cnt_stable), 5);
      check_eq("t3_upd_count", n_upd, 0);
      check_eq("t3_evt_cycles", n_evt_cycles, 0);

      // --- held skip, silent increment, dropped wrap
      hold(3, 6, 1'b1);
      hold(3, 2, 1'b1);
      hold(12, 6, 1'b0);
      check_eq("t4_skip_valid", int'(evt_valid), 1);
      check_eq("t4_skip_code", int'(evt_code), 2);
      check_eq("t4_skip_val", int'(evt_value), 12);
      hold(13, 6, 1'b0);
      hold(14, 6, 1'b0);
      hold(15, 6, 1'b0);
      check_eq("t4_held_code", int'(evt_code), 2);
      check_eq("t4_held_val", int'(evt_value), 12);
      check_eq("t4_no_ovf_yet", int'(evt_overflow), 0);
      hold(0, 6, 1'b0);
      check_eq("t4_ovf", int'(evt_overflow), 1);
      check_eq("t4_wrap_count", int'(wrap_count), 2);
      check_eq("t4_still_code", int'(evt_code), 2);

      // --- pop and load on the same edge
      step(0, 1'b1, 1'b0, 1'b0);
      hold(0, 2, 1'b1);
      hold(15, 6, 1'b0);
      check_eq("t5_pending", int'(evt_valid), 1);
      hold(0, 3, 1'b0);
      step(0, 1'b0, 1'b1, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0);
      check_eq("t5_valid", int'(evt_valid), 1);
      check_eq("t5_code", int'(evt_code), 1);
      check_eq("t5_val", int'(evt_value), 0);
      check_eq("t5_ovf", int'(evt_overflow), 0);
      check_eq("t5_wrap_count", int'(wrap_count), 1);

      // --- clr with a pending event and wrap_count 3
      hold(0, 1, 1'b1);
      hold(15, 6, 1'b1);
      hold(0, 6, 1'b1);
      hold(15, 6, 1'b1);
      hold(0, 6, 1'b1);
      hold(7, 6, 1'b0);
      check_eq("t6_wrap_count", int'(wrap_count), 3);
      check_eq("t6_pending", int'(evt_valid), 1);
      step(7, 1'b1, 1'b0, 1'b0);
      check_eq("t6_clr_valid", int'(evt_valid), 0);
      check_eq("t6_clr_wc", int'(wrap_count), 0);
      check_eq("t6_clr_ovf", int'(evt_overflow), 0);
      check_eq("t6_clr_cs", int'(cnt_stable), 7);
      clear_obs();
      hold(7, 6, 1'b0);
      check_eq("t6_silent", n_evt_cycles, 0);
      check_eq("t6_sv", int'(stable_valid), 1);

      // --- randomized phase
      for (int seg = 0; seg < 500; seg++) begin
         int v, len;
         if ($urandom_range(0, 2) == 0) v = (m_prev + 1) % MODV;
         else v = int'($urandom_range(0, MODV - 1));
         len = int'($urandom_range(1, 7));
         for (int k = 0; k < len; k++) begin
            bit c, r, rdy;
            rdy = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 299) == 0);
            c   = ($urandom_range(0, 39) == 0) && !would_accept(v);
            step(v, c, rdy, r);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
